// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with a result accumulator.
// Optional registered zero/negative flags are enabled by defining LOGIC_UNIT_FLAGS_EN.
module logic_unit_pipe #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_acc,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result
`ifdef LOGIC_UNIT_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_neg
`endif
);

   // Handshake: a stage transfers on valid && ready; valid never drops and its
   // payload never changes until the transfer. Ready back-propagates
   // combinationally from out_ready, so a full pipe still moves every cycle.

   logic             s1_valid;
   logic [2:0]       s1_op;
   logic             s1_acc;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s2_valid;
   logic             s2_ready;
   logic             advance;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] result;

   assign s2_ready  = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_ready;
   assign advance   = s1_valid && s2_ready;
   assign out_valid = s2_valid;

   // Operand A comes from the accumulator at the moment of advance, so chained
   // accumulate ops see the previous op's result without a bubble.
   assign op_a = s1_acc ? acc_q : s1_a;

   always_comb begin
      result = '0;
      case (s1_op)
         3'b000:  result = op_a & s1_b;
         3'b001:  result = op_a | s1_b;
         3'b010:  result = op_a ^ s1_b;
         3'b011:  result = ~(op_a | s1_b);
         3'b100:  result = ~(op_a & s1_b);
         3'b101:  result = ~(op_a ^ s1_b);
         3'b110:  result = op_a & ~s1_b;
         default: result = op_a;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_acc   <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op  <= in_op;
            s1_acc <= in_acc;
            s1_a   <= in_a;
            s1_b   <= in_b;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid   <= 1'b0;
         out_result <= '0;
         acc_q      <= '0;
      end else if (advance) begin
         s2_valid   <= 1'b1;
         out_result <= result;
         acc_q      <= result;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_zero <= 1'b0;
         out_neg  <= 1'b0;
      end else if (advance) begin
         out_zero <= (result == '0);
         out_neg  <= result[WIDTH-1];
      end
   end
`endif

endmodule
